// File: rtl/ps2_mouse_pkg.sv
// Shared constants, state encoding and decode helpers for the PS/2 mouse controller.
package ps2_mouse_pkg;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_RATE      = 8'hF3;
  localparam logic [7:0] CMD_STREAM_EN = 8'hF4;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  typedef enum logic [3:0] {
    S_RST_TX,
    S_RST_ACK,
    S_BAT,
    S_ID,
    S_RATE_TX,
    S_RATE_ACK,
    S_VAL_TX,
    S_VAL_ACK,
    S_EN_TX,
    S_EN_ACK,
    S_PKT1,
    S_PKT2,
    S_PKT3,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [8:0] xm;
    logic [8:0] ym;
    logic [2:0] btn;
  } motion_t;

  function automatic logic is_tx(input state_t s);
    return (s == S_RST_TX) || (s == S_RATE_TX) || (s == S_VAL_TX) || (s == S_EN_TX);
  endfunction

  function automatic logic is_expect(input state_t s);
    return (s == S_RST_ACK) || (s == S_BAT) || (s == S_ID) ||
           (s == S_RATE_ACK) || (s == S_VAL_ACK) || (s == S_EN_ACK);
  endfunction

  // Successor of each init state on success; other states map to themselves.
  function automatic state_t init_next(input state_t s);
    case (s)
      S_RST_TX:   return S_RST_ACK;
      S_RST_ACK:  return S_BAT;
      S_BAT:      return S_ID;
      S_ID:       return S_RATE_TX;
      S_RATE_TX:  return S_RATE_ACK;
      S_RATE_ACK: return S_VAL_TX;
      S_VAL_TX:   return S_VAL_ACK;
      S_VAL_ACK:  return S_EN_TX;
      S_EN_TX:    return S_EN_ACK;
      S_EN_ACK:   return S_PKT1;
      default:    return s;
    endcase
  endfunction

  function automatic logic [7:0] expected_rsp(input state_t s);
    case (s)
      S_BAT:   return RSP_BAT_OK;
      S_ID:    return RSP_ID;
      default: return RSP_ACK;
    endcase
  endfunction

  function automatic logic [7:0] tx_cmd(input state_t s, input logic [7:0] rate);
    case (s)
      S_RATE_TX: return CMD_RATE;
      S_VAL_TX:  return rate;
      S_EN_TX:   return CMD_STREAM_EN;
      default:   return CMD_RESET;
    endcase
  endfunction

endpackage

// File: rtl/ps2_timeout.sv
// Saturating down-counter: tracks cycles spent waiting in one state and flags expiry.
module ps2_timeout #(
  parameter int unsigned TIMEOUT_CYC = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TW-1:0] count;

  // count holds the cycles remaining; zero means the current cycle is the last allowed one
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= TW'(TIMEOUT_CYC - 1);
    end else if (en && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign expired_c = en && (count == '0);

endmodule

// File: rtl/mouse_ctrl.sv
// PS/2 mouse protocol sequencer: power-up handshake, then 3-byte movement packet assembly.
module mouse_ctrl
  import ps2_mouse_pkg::*;
#(
  parameter logic [7:0]  SAMPLE_RATE = 8'd100,
  parameter int unsigned TIMEOUT_CYC = 25_000_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  input  logic       tx_done_tick,
  output logic [7:0] tx_data,
  output logic       wr_ps2,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic [2:0] btnm,
  output logic       m_done_tick,
  output logic       init_done,
  output logic       init_err
);

  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t               state;
  state_t               nxt_c;
  logic                 boot;
  logic [RETRY_W-1:0]   retry;
  logic                 sign_x;
  logic                 sign_y;
  logic [2:0]           btn1;
  logic [7:0]           byte2;
  motion_t              motion;
  logic                 timed_c;
  logic                 expired_c;
  logic                 advance_c;
  logic                 fail_c;

  assign timed_c = is_tx(state) || is_expect(state);

  ps2_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clr       (advance_c || fail_c),
    .en        (timed_c),
    .expired_c (expired_c)
  );

  // Init-phase decision; a received byte takes precedence over a coincident expiry
  always_comb begin
    advance_c = 1'b0;
    fail_c    = 1'b0;
    if (is_tx(state)) begin
      if (!boot && tx_done_tick) begin
        advance_c = 1'b1;
      end else if (expired_c) begin
        fail_c = 1'b1;
      end
    end else if (is_expect(state)) begin
      if (rx_done_tick) begin
        if (rx_data == expected_rsp(state)) begin
          advance_c = 1'b1;
        end else begin
          fail_c = 1'b1;
        end
      end else if (expired_c) begin
        fail_c = 1'b1;
      end
    end
    nxt_c = init_next(state);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RST_TX;
      boot        <= 1'b1;
      retry       <= '0;
      tx_data     <= 8'h00;
      wr_ps2      <= 1'b0;
      motion      <= '0;
      m_done_tick <= 1'b0;
      init_done   <= 1'b0;
      init_err    <= 1'b0;
      sign_x      <= 1'b0;
      sign_y      <= 1'b0;
      btn1        <= 3'b000;
      byte2       <= 8'h00;
    end else begin
      wr_ps2      <= 1'b0;
      m_done_tick <= 1'b0;

      // The reset command goes out on the first cycle out of reset
      if (boot) begin
        boot    <= 1'b0;
        wr_ps2  <= 1'b1;
        tx_data <= CMD_RESET;
      end

      if (fail_c) begin
        if (retry < RETRY_W'(MAX_RETRY)) begin
          retry   <= retry + RETRY_W'(1);
          state   <= S_RST_TX;
          wr_ps2  <= 1'b1;
          tx_data <= CMD_RESET;
        end else begin
          state    <= S_ERR;
          init_err <= 1'b1;
        end
      end else if (advance_c) begin
        state <= nxt_c;
        if (is_tx(nxt_c)) begin
          wr_ps2  <= 1'b1;
          tx_data <= tx_cmd(nxt_c, SAMPLE_RATE);
        end
        if (nxt_c == S_PKT1) begin
          init_done <= 1'b1;
        end
      end

      // Stream mode: bit3 of byte1 is always set, so a clear bit3 means we are out of step
      if (rx_done_tick) begin
        case (state)
          S_PKT1: begin
            if (rx_data[3]) begin
              sign_x <= rx_data[4];
              sign_y <= rx_data[5];
              btn1   <= rx_data[2:0];
              state  <= S_PKT2;
            end
          end
          S_PKT2: begin
            byte2 <= rx_data;
            state <= S_PKT3;
          end
          S_PKT3: begin
            motion.xm   <= {sign_x, byte2};
            motion.ym   <= {sign_y, rx_data};
            motion.btn  <= btn1;
            m_done_tick <= 1'b1;
            state       <= S_PKT1;
          end
          default: ;
        endcase
      end
    end
  end

  assign xm   = motion.xm;
  assign ym   = motion.ym;
  assign btnm = motion.btn;

endmodule

// File: tb/tb_mouse_ctrl.sv
// Directed bench for mouse_ctrl: init handshake, packet vectors, resync, retry, timeout and reset abort.
module tb_mouse_ctrl;

  localparam int unsigned T = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done_tick = 1'b0;
  logic       tx_done_tick = 1'b0;
  logic [7:0] tx_data;
  logic       wr_ps2;
  logic [8:0] xm;
  logic [8:0] ym;
  logic [2:0] btnm;
  logic       m_done_tick;
  logic       init_done;
  logic       init_err;

  int n_pass = 0;
  int n_total = 0;
  int wr_count = 0;

  typedef struct {
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    logic [8:0] xm;
    logic [8:0] ym;
    logic [2:0] btn;
  } pkt_vec_t;

  pkt_vec_t vecs[5];

  mouse_ctrl #(
    .SAMPLE_RATE (8'd100),
    .TIMEOUT_CYC (T),
    .MAX_RETRY   (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .tx_done_tick (tx_done_tick),
    .tx_data      (tx_data),
    .wr_ps2       (wr_ps2),
    .xm           (xm),
    .ym           (ym),
    .btnm         (btnm),
    .m_done_tick  (m_done_tick),
    .init_done    (init_done),
    .init_err     (init_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_ps2) wr_count <= wr_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
  endtask

  // Wait for a transmit request, check the byte, then acknowledge it a few cycles later
  task automatic expect_tx(input logic [7:0] exp, input string name);
    int n = 0;
    while (!wr_ps2 && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_wr"}, 32'(wr_ps2), 32'd1);
    chk(name, 32'(tx_data), 32'(exp));
    tick();
    tick();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_wr"}, 32'(wr_ps2), 32'd0);
    chk({name, "_txd"}, 32'(tx_data), 32'd0);
    chk({name, "_pos"}, {11'd0, xm, ym, btnm}, 32'd0);
    chk({name, "_flags"}, {29'd0, m_done_tick, init_done, init_err}, 32'd0);
  endtask

  // Hold reset, check the cleared outputs, release, then check the reset command fires immediately
  task automatic do_reset(input int cycles, input string name);
    reset = 1'b1;
    repeat (cycles) tick();
    check_idle_outputs(name);
    reset = 1'b0;
    tick();
    chk({name, "_wr_first"}, 32'(wr_ps2), 32'd1);
    chk({name, "_ff_first"}, 32'(tx_data), 32'hFF);
  endtask

  task automatic finish_init(input string name);
    send_byte(8'hAA);
    send_byte(8'h00);
    expect_tx(8'hF3, {name, "_f3"});
    send_byte(8'hFA);
    expect_tx(8'h64, {name, "_rate"});
    send_byte(8'hFA);
    expect_tx(8'hF4, {name, "_f4"});
    chk({name, "_not_yet"}, 32'(init_done), 32'd0);
    send_byte(8'hFA);
    chk({name, "_init_done"}, 32'(init_done), 32'd1);
  endtask

  initial begin
    int base;
    int n;

    vecs[0] = '{8'h19, 8'hF4, 8'hFE, 9'h1F4, 9'h0FE, 3'b001};
    vecs[1] = '{8'h08, 8'h10, 8'h20, 9'h010, 9'h020, 3'b000};
    vecs[2] = '{8'h3F, 8'hFF, 8'h80, 9'h1FF, 9'h180, 3'b111};
    vecs[3] = '{8'hCA, 8'h01, 8'h02, 9'h001, 9'h002, 3'b010};
    vecs[4] = '{8'h2C, 8'h7F, 8'h00, 9'h07F, 9'h100, 3'b100};

    // Nominal init
    base = wr_count;
    do_reset(3, "rst");
    expect_tx(8'hFF, "nom_ff");
    send_byte(8'hFA);
    finish_init("nom");
    tick();
    chk("nom_wr_count", 32'(wr_count - base), 32'd4);

    // Packet vectors, bytes delivered back to back
    for (int i = 0; i < 5; i++) begin
      send_byte(vecs[i].b1);
      send_byte(vecs[i].b2);
      chk($sformatf("pkt%0d_early", i), 32'(m_done_tick), 32'd0);
      send_byte(vecs[i].b3);
      chk($sformatf("pkt%0d_done", i), 32'(m_done_tick), 32'd1);
      chk($sformatf("pkt%0d_xm", i), 32'(xm), 32'(vecs[i].xm));
      chk($sformatf("pkt%0d_ym", i), 32'(ym), 32'(vecs[i].ym));
      chk($sformatf("pkt%0d_btn", i), 32'(btnm), 32'(vecs[i].btn));
      tick();
      chk($sformatf("pkt%0d_pulse", i), 32'(m_done_tick), 32'd0);
    end

    // Resync: a byte with bit3 clear is dropped
    send_byte(8'h02);
    send_byte(8'h08);
    send_byte(8'h10);
    chk("resync_early", 32'(m_done_tick), 32'd0);
    send_byte(8'h20);
    chk("resync_done", 32'(m_done_tick), 32'd1);
    chk("resync_pos", {14'd0, xm, ym}, {14'd0, 9'h010, 9'h020});
    tick();

    // Reset after byte2 of a packet
    send_byte(8'h19);
    send_byte(8'hF4);
    rx_data = 8'hFE;
    do_reset(1, "midpkt");
    chk("midpkt_no_tick", 32'(m_done_tick), 32'd0);

    // NAK to the reset command, then recovery; the FA ack arrives on the expiry cycle
    expect_tx(8'hFF, "nak_ff");
    send_byte(8'hFE);
    chk("nak_retry_wr", 32'(wr_ps2), 32'd1);
    chk("nak_init_done", 32'(init_done), 32'd0);
    expect_tx(8'hFF, "nak_ff2");
    repeat (T - 1) tick();
    send_byte(8'hFA);
    chk("race_byte_wins", 32'(wr_ps2), 32'd0);
    finish_init("rec");

    // Silent mouse: four reset commands separated by a full timeout, then error
    base = wr_count;
    do_reset(2, "sil");
    expect_tx(8'hFF, "sil_ff0");
    for (int r = 1; r <= 3; r++) begin
      n = 0;
      while (!wr_ps2 && n < int'(T) + 20) begin
        tick();
        n++;
      end
      chk($sformatf("sil_gap%0d", r), 32'(n), 32'(T));
      expect_tx(8'hFF, $sformatf("sil_ff%0d", r));
    end
    repeat (T - 1) tick();
    chk("sil_err_early", 32'(init_err), 32'd0);
    tick();
    chk("sil_err", 32'(init_err), 32'd1);
    repeat (2 * T) tick();
    chk("sil_wr_count", 32'(wr_count - base), 32'd4);
    chk("sil_err_sticky", {30'd0, init_err, init_done}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
